// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, selectable read-during-write, optional
// output register and a post-reset clear sequencer that fills the array.
module dpram_be_clr #(
  parameter int               width          = 32,
  parameter int               widthad        = 10,
  parameter int               byte_width     = 8,
  parameter int               rdw_mode       = 0,
  parameter int               out_reg        = 0,
  parameter int               clear_on_reset = 1,
  parameter logic [width-1:0] clear_value    = '0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  output logic                        busy,
  output logic                        collision,
  input  logic                        wren_a,
  input  logic                        wren_b,
  input  logic                        rden_a,
  input  logic                        rden_b,
  input  logic [widthad-1:0]          address_a,
  input  logic [widthad-1:0]          address_b,
  input  logic [width-1:0]            data_a,
  input  logic [width-1:0]            data_b,
  input  logic [width/byte_width-1:0] byteena_a,
  input  logic [width/byte_width-1:0] byteena_b,
  output logic [width-1:0]            q_a,
  output logic [width-1:0]            q_b,
  output logic                        valid_a,
  output logic                        valid_b
);
  localparam int nb    = width / byte_width;
  localparam int depth = 1 << widthad;

  typedef enum logic {CLEAR, READY} state_t;

  state_t             state_q;
  logic [widthad-1:0] clr_cnt_q;
  logic               busy_q;
  logic               collision_q, collision_d;
  logic [width-1:0]   mem_q [depth];

  logic [width-1:0]   mask_a, mask_b;
  logic [width-1:0]   fin_a, fin_b;
  logic [width-1:0]   rd_word_a_d, rd_word_b_d;
  logic               ready, wr_a, wr_b, rd_a, rd_b;

  for (genvar i = 0; i < nb; i++) begin : g_lane
    assign mask_a[i*byte_width +: byte_width] = {byte_width{byteena_a[i]}};
    assign mask_b[i*byte_width +: byte_width] = {byte_width{byteena_b[i]}};
  end

  // Ports are dead during the reset cycle as well as while clearing.
  assign ready = reset_n && (state_q == READY);
  assign wr_a  = ready && wren_a;
  assign wr_b  = ready && wren_b;
  assign rd_a  = ready && rden_a;
  assign rd_b  = ready && rden_b;

  // fin_x is the word that will sit at address_x after this edge; B is merged
  // first so that lanes enabled on both ports end up holding port A data.
  always_comb begin
    fin_a = mem_q[address_a];
    if (wr_b && (address_b == address_a)) fin_a = (fin_a & ~mask_b) | (data_b & mask_b);
    if (wr_a) fin_a = (fin_a & ~mask_a) | (data_a & mask_a);

    fin_b = mem_q[address_b];
    if (wr_b) fin_b = (fin_b & ~mask_b) | (data_b & mask_b);
    if (wr_a && (address_a == address_b)) fin_b = (fin_b & ~mask_a) | (data_a & mask_a);

    rd_word_a_d = mem_q[address_a];
    rd_word_b_d = mem_q[address_b];
    if (rdw_mode == 0) begin
      if (wr_a) rd_word_a_d = fin_a;
      if (wr_b) rd_word_b_d = fin_b;
    end

    collision_d = wr_a && wr_b && (address_a == address_b) && (|byteena_a) && (|byteena_b);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= (clear_on_reset != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
      busy_q    <= (clear_on_reset != 0);
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + widthad'(1);
          if (clr_cnt_q == '1) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) collision_q <= 1'b0;
    else          collision_q <= collision_d;
  end

  always_ff @(posedge clock) begin
    if (reset_n && (state_q == CLEAR)) begin
      mem_q[clr_cnt_q] <= clear_value;
    end else begin
      if (wr_a) mem_q[address_a] <= fin_a;
      if (wr_b) mem_q[address_b] <= fin_b;
    end
  end

  dpram_be_clr_rdpipe #(.width(width), .out_reg(out_reg)) u_pipe_a (
    .clock(clock), .reset_n(reset_n), .rd(rd_a), .rd_word(rd_word_a_d),
    .q(q_a), .valid(valid_a)
  );

  dpram_be_clr_rdpipe #(.width(width), .out_reg(out_reg)) u_pipe_b (
    .clock(clock), .reset_n(reset_n), .rd(rd_b), .rd_word(rd_word_b_d),
    .q(q_b), .valid(valid_b)
  );

  assign busy      = busy_q;
  assign collision = collision_q;
endmodule

// Per-port read pipeline: data registers only load on a valid read, so q holds.
module dpram_be_clr_rdpipe #(
  parameter int width   = 32,
  parameter int out_reg = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rd,
  input  logic [width-1:0] rd_word,
  output logic [width-1:0] q,
  output logic             valid
);
  logic [width-1:0] s1_q;
  logic             vld1_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_q   <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= rd;
      if (rd) s1_q <= rd_word;
    end
  end

  if (out_reg != 0) begin : g_oreg
    logic [width-1:0] s2_q;
    logic             vld2_q;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        s2_q   <= '0;
        vld2_q <= 1'b0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) s2_q <= s1_q;
      end
    end

    assign q     = s2_q;
    assign valid = vld2_q;
  end else begin : g_noreg
    assign q     = s1_q;
    assign valid = vld1_q;
  end
endmodule
